// File: rtl/menu_pkg.sv
// Shared types and defaults for the menu/screen sequencer.
package menu_pkg;

  // Screen codes presented to the output mux; 2'b11 is never driven.
  typedef enum logic [1:0] {
    SCR_MENU = 2'b00,
    SCR_GAME = 2'b01,
    SCR_END  = 2'b10
  } screen_t;

  // Sequencer states.
  typedef enum logic [2:0] {
    MENU,
    ARMED,
    START_PEND,
    GAME,
    END_PEND,
    END_SCR
  } state_t;

  // Default screen geometry of the 1024x768 pipeline.
  localparam int unsigned SCREEN_W = 1024;
  localparam int unsigned SCREEN_H = 768;
  localparam int unsigned BORDER_W = 3;

  // Default start-button geometry and end-screen timing.
  localparam int unsigned BTN_X_DEF      = 412;
  localparam int unsigned BTN_Y_DEF      = 334;
  localparam int unsigned BTN_W_DEF      = 200;
  localparam int unsigned BTN_H_DEF      = 100;
  localparam int unsigned END_FRAMES_DEF = 180;
  localparam int unsigned MIN_SKIP_DEF   = 30;

  localparam int unsigned CNT_W = 8;

  // Half-open span test lo <= v < lo+len, done in 13 bits so lo+len cannot wrap.
  function automatic logic in_span(input logic [11:0] v,
                                   input int unsigned lo,
                                   input int unsigned len);
    logic [12:0] w_v;
    w_v = {1'b0, v};
    return (w_v >= 13'(lo)) && (w_v < 13'(lo + len));
  endfunction

endpackage

// File: rtl/menu_if.sv
// Timing/mouse/game-logic signals into the sequencer and its screen controls out.
interface menu_if;
  logic        vblnk_in;
  logic [11:0] mouse_x;
  logic [11:0] mouse_y;
  logic        mouse_left;
  logic        game_over_in;
  logic        winner_in;
  logic [1:0]  screen_sel;
  logic        btn_hover;
  logic        btn_pressed;
  logic        game_rst;
  logic        winner_out;

  // Source side: timing generator, mouse and game logic.
  modport master (
    output vblnk_in, mouse_x, mouse_y, mouse_left, game_over_in, winner_in,
    input  screen_sel, btn_hover, btn_pressed, game_rst, winner_out
  );

  // Sequencer side.
  modport slave (
    input  vblnk_in, mouse_x, mouse_y, mouse_left, game_over_in, winner_in,
    output screen_sel, btn_hover, btn_pressed, game_rst, winner_out
  );
endinterface

// File: rtl/menu_btn_hit.sv
// Registered pointer-in-rectangle test for one menu button.
module menu_btn_hit
  import menu_pkg::*;
#(
  parameter int unsigned BTN_X = BTN_X_DEF,
  parameter int unsigned BTN_Y = BTN_Y_DEF,
  parameter int unsigned BTN_W = BTN_W_DEF,
  parameter int unsigned BTN_H = BTN_H_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  output logic        o_hit
);

  logic w_hit;
  logic r_hit;

  assign w_hit = in_span(i_x, BTN_X, BTN_W) && in_span(i_y, BTN_Y, BTN_H);

  // Register the hit result (one cycle pointer-to-hover latency).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_hit <= 1'b0;
    else          r_hit <= w_hit;
  end

  assign o_hit = r_hit;

endmodule

// File: rtl/menu_ctl.sv
// Screen-mode sequencer: menu -> game -> end screen, committed on vblnk rising edges.
module menu_ctl
  import menu_pkg::*;
#(
  parameter int unsigned BTN_X      = BTN_X_DEF,
  parameter int unsigned BTN_Y      = BTN_Y_DEF,
  parameter int unsigned BTN_W      = BTN_W_DEF,
  parameter int unsigned BTN_H      = BTN_H_DEF,
  parameter int unsigned END_FRAMES = END_FRAMES_DEF,
  parameter int unsigned MIN_SKIP   = MIN_SKIP_DEF
) (
  input  logic   clk,
  input  logic   rst,
  menu_if.slave  mif
);

  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(END_FRAMES - 1);
  localparam logic [CNT_W-1:0] SKIP_MIN   = CNT_W'(MIN_SKIP);

  state_t           r_state, w_state_nxt;
  screen_t          r_screen, w_screen_nxt;
  logic             r_game_rst, w_game_rst_nxt;
  logic             r_winner, w_winner_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_skip, w_skip_nxt;
  logic             r_vblnk_d, r_left_d;
  logic             w_frame_start, w_click, w_in_btn, w_on_menu;

  menu_btn_hit #(
    .BTN_X (BTN_X),
    .BTN_Y (BTN_Y),
    .BTN_W (BTN_W),
    .BTN_H (BTN_H)
  ) u_start_btn (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_x     (mif.mouse_x),
    .i_y     (mif.mouse_y),
    .o_hit   (w_in_btn)
  );

  assign w_frame_start = mif.vblnk_in & ~r_vblnk_d;
  assign w_click       = mif.mouse_left & ~r_left_d;

  // Delay vblank and mouse button by one cycle for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vblnk_d <= 1'b0;
      r_left_d  <= 1'b0;
    end else begin
      r_vblnk_d <= mif.vblnk_in;
      r_left_d  <= mif.mouse_left;
    end
  end

  // State, screen select and end-screen bookkeeping registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= MENU;
      r_screen   <= SCR_MENU;
      r_game_rst <= 1'b0;
      r_winner   <= 1'b0;
      r_cnt      <= '0;
      r_skip     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_screen   <= w_screen_nxt;
      r_game_rst <= w_game_rst_nxt;
      r_winner   <= w_winner_nxt;
      r_cnt      <= w_cnt_nxt;
      r_skip     <= w_skip_nxt;
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_screen_nxt   = r_screen;
    w_game_rst_nxt = 1'b0;
    w_winner_nxt   = r_winner;
    w_cnt_nxt      = r_cnt;
    w_skip_nxt     = r_skip;
    unique case (r_state)
      MENU: begin
        if (w_click && w_in_btn) w_state_nxt = ARMED;
      end
      ARMED: begin
        if (!mif.mouse_left) w_state_nxt = w_in_btn ? START_PEND : MENU;
      end
      START_PEND: begin
        if (w_frame_start) begin
          w_screen_nxt   = SCR_GAME;
          w_game_rst_nxt = 1'b1;
          w_state_nxt    = GAME;
        end
      end
      GAME: begin
        if (mif.game_over_in) begin
          w_winner_nxt = mif.winner_in;
          w_state_nxt  = END_PEND;
        end
      end
      END_PEND: begin
        if (w_frame_start) begin
          w_screen_nxt = SCR_END;
          w_cnt_nxt    = '0;
          w_skip_nxt   = 1'b0;
          w_state_nxt  = END_SCR;
        end
      end
      END_SCR: begin
        // A skip request only acts at a later frame start: the exit test
        // below uses the already-registered r_skip.
        if (w_click && (r_cnt >= SKIP_MIN)) w_skip_nxt = 1'b1;
        if (w_frame_start) begin
          if ((r_cnt == LAST_FRAME) || r_skip) begin
            w_screen_nxt = SCR_MENU;
            w_cnt_nxt    = '0;
            w_skip_nxt   = 1'b0;
            w_state_nxt  = MENU;
          end else if (r_cnt != '1) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_screen_nxt = SCR_MENU;
        w_state_nxt  = MENU;
      end
    endcase
  end

  assign w_on_menu = (r_state == MENU) || (r_state == ARMED) || (r_state == START_PEND);

  assign mif.screen_sel  = r_screen;
  assign mif.btn_hover   = w_in_btn & w_on_menu;
  assign mif.btn_pressed = w_in_btn & (r_state == ARMED);
  assign mif.game_rst    = r_game_rst;
  assign mif.winner_out  = r_winner;

endmodule

// File: tb/tb_menu_ctl.sv
// Bench for menu_ctl: per-cycle reference model plus directed corner sequences.
module tb_menu_ctl;
  import menu_pkg::*;

  localparam int FRAME      = 16;
  localparam int VB_HI      = 3;
  localparam int END_FRAMES = 180;
  localparam int MIN_SKIP   = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;

  menu_if bus ();

  menu_ctl #(
    .BTN_X      (412),
    .BTN_Y      (334),
    .BTN_W      (200),
    .BTN_H      (100),
    .END_FRAMES (END_FRAMES),
    .MIN_SKIP   (MIN_SKIP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mif (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fs_cnt  = 0;
  logic vb_prev = 1'b0;

  // Reference model: screen shown plus a few flags describing progress.
  logic [1:0] m_scr;
  logic m_armed, m_swait, m_ewait, m_skip, m_hit, m_pvb, m_pleft, m_win, m_grst;
  int   m_frames;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic        hover;
  } hov_vec_t;

  function automatic logic hit(input logic [11:0] x, input logic [11:0] y);
    int ix, iy;
    ix = int'(x);
    iy = int'(y);
    return (ix >= 412) && (ix < 612) && (iy >= 334) && (iy < 434);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scr = 2'd0; m_armed = 0; m_swait = 0; m_ewait = 0; m_skip = 0;
    m_hit = 0; m_pvb = 0; m_pleft = 0; m_win = 0; m_grst = 0; m_frames = 0;
  endtask

  task automatic model_step();
    logic fs, ck, nskip;
    fs = bus.vblnk_in & ~m_pvb;
    ck = bus.mouse_left & ~m_pleft;
    m_grst = 0;
    case (m_scr)
      2'd0: begin
        if (m_swait) begin
          if (fs) begin m_scr = 2'd1; m_grst = 1; m_swait = 0; end
        end else if (m_armed) begin
          if (!bus.mouse_left) begin m_armed = 0; m_swait = m_hit; end
        end else if (ck && m_hit) begin
          m_armed = 1;
        end
      end
      2'd1: begin
        if (m_ewait) begin
          if (fs) begin m_scr = 2'd2; m_frames = 0; m_skip = 0; m_ewait = 0; end
        end else if (bus.game_over_in) begin
          m_win = bus.winner_in; m_ewait = 1;
        end
      end
      default: begin
        nskip = m_skip || (ck && (m_frames >= MIN_SKIP));
        if (fs && ((m_frames == END_FRAMES - 1) || m_skip)) begin
          m_scr = 2'd0; m_frames = 0; m_skip = 0;
        end else begin
          if (fs && (m_frames < 255)) m_frames++;
          m_skip = nskip;
        end
      end
    endcase
    m_hit   = hit(bus.mouse_x, bus.mouse_y);
    m_pvb   = bus.vblnk_in;
    m_pleft = bus.mouse_left;
  endtask

  function automatic logic [5:0] dut_vec();
    return {bus.screen_sel, bus.btn_hover, bus.btn_pressed, bus.game_rst, bus.winner_out};
  endfunction

  function automatic logic [5:0] model_vec();
    return {m_scr, m_hit && (m_scr == 2'd0), m_armed && m_hit, m_grst, m_win};
  endfunction

  // One clock: update model at the edge, compare 1 time unit later, advance frame timing.
  task automatic step();
    @(posedge clk);
    if (bus.vblnk_in && !vb_prev) fs_cnt++;
    vb_prev = bus.vblnk_in;
    if (rst) model_step();
    else     model_reset();
    #1;
    chk($sformatf("cycle%0d", cyc), 32'(dut_vec()), 32'(model_vec()));
    cyc++;
    bus.vblnk_in = ((cyc % FRAME) < VB_HI);
  endtask

  task automatic wait_screen(input logic [1:0] s, input int budget, input string name);
    int n;
    n = 0;
    while ((bus.screen_sel !== s) && (n < budget)) begin
      step();
      n++;
    end
    chk(name, 32'(bus.screen_sel), 32'(s));
  endtask

  task automatic wait_fs(input int target, input string name);
    int n;
    n = 0;
    while ((fs_cnt < target) && (n < (target + 2) * FRAME)) begin
      step();
      n++;
    end
    chk(name, fs_cnt, target);
  endtask

  task automatic click_once();
    bus.mouse_left = 1'b1;
    step();
    bus.mouse_left = 1'b0;
    step();
  endtask

  task automatic do_start(input string name);
    bus.mouse_x = 12'd500;
    bus.mouse_y = 12'd380;
    step();
    bus.mouse_left = 1'b1;
    repeat (10) step();
    chk({name, "_pressed"}, 32'(bus.btn_pressed), 32'd1);
    bus.mouse_left = 1'b0;
    wait_screen(2'b01, 3 * FRAME, {name, "_game"});
    chk({name, "_grst"}, 32'(bus.game_rst), 32'd1);
    step();
    chk({name, "_grst_once"}, 32'(bus.game_rst), 32'd0);
  endtask

  task automatic do_game_over(input logic w, input string name);
    repeat (5) step();
    bus.winner_in    = w;
    bus.game_over_in = 1'b1;
    step();
    bus.game_over_in = 1'b0;
    bus.winner_in    = ~w;
    step();
    chk({name, "_winner"}, 32'(bus.winner_out), 32'(w));
    wait_screen(2'b10, 3 * FRAME, {name, "_end"});
    fs_cnt = 0;
  endtask

  hov_vec_t hv[10];

  initial begin
    hv[0] = '{12'd611,  12'd380,  1'b1};
    hv[1] = '{12'd612,  12'd380,  1'b0};
    hv[2] = '{12'd412,  12'd380,  1'b1};
    hv[3] = '{12'd411,  12'd380,  1'b0};
    hv[4] = '{12'd500,  12'd334,  1'b1};
    hv[5] = '{12'd500,  12'd333,  1'b0};
    hv[6] = '{12'd500,  12'd433,  1'b1};
    hv[7] = '{12'd500,  12'd434,  1'b0};
    hv[8] = '{12'd0,    12'd0,    1'b0};
    hv[9] = '{12'd4095, 12'd4095, 1'b0};

    bus.vblnk_in = 0; bus.mouse_x = '0; bus.mouse_y = '0;
    bus.mouse_left = 0; bus.game_over_in = 0; bus.winner_in = 0;
    model_reset();

    // Reset asserted with no clock edge yet.
    #2 rst = 1'b0;
    #1 chk("reset_outs", 32'(dut_vec()), 32'd0);
    repeat (3) step();
    rst = 1'b1;
    repeat (3 * FRAME) step();
    chk("idle_menu", 32'(bus.screen_sel), 32'd0);

    // Button rectangle edges.
    for (int i = 0; i < 10; i++) begin
      bus.mouse_x = hv[i].x;
      bus.mouse_y = hv[i].y;
      step();
      chk($sformatf("hover_vec%0d", i), 32'(bus.btn_hover), 32'(hv[i].hover));
    end

    // Press on button, release outside: cancelled.
    bus.mouse_x = 12'd500; bus.mouse_y = 12'd380;
    step();
    bus.mouse_left = 1'b1;
    repeat (3) step();
    chk("cancel_armed", 32'(bus.btn_pressed), 32'd1);
    bus.mouse_x = 12'd100; bus.mouse_y = 12'd100;
    step();
    bus.mouse_left = 1'b0;
    repeat (2 * FRAME) step();
    chk("cancel_screen", 32'(bus.screen_sel), 32'd0);

    // Start, then end screen with automatic return.
    do_start("start1");
    do_game_over(1'b1, "auto");
    wait_screen(2'b00, (END_FRAMES + 5) * FRAME, "auto_return");
    chk("auto_frames", fs_cnt, END_FRAMES);

    // Early click ignored, click past MIN_SKIP returns at next frame.
    do_start("start2");
    do_game_over(1'b0, "skip");
    wait_fs(10, "skip_f10");
    step();
    click_once();
    wait_fs(40, "skip_f40");
    chk("skip_early_ignored", 32'(bus.screen_sel), 32'd2);
    step();
    click_once();
    fs_cnt = 0;
    wait_screen(2'b00, 3 * FRAME, "skip_return");
    chk("skip_frames", fs_cnt, 1);

    // Click coinciding with a frame start, button then held through return.
    do_start("start3");
    do_game_over(1'b1, "coinc");
    wait_fs(35, "coinc_f35");
    for (int n = 0; (n <= FRAME) && ((cyc % FRAME) != 0); n++) step();
    bus.mouse_x = 12'd500; bus.mouse_y = 12'd380;
    bus.mouse_left = 1'b1;
    fs_cnt = 0;
    wait_screen(2'b00, 3 * FRAME, "coinc_return");
    chk("coinc_frames", fs_cnt, 2);
    repeat (20) step();
    chk("held_not_armed", 32'(bus.btn_pressed), 32'd0);
    bus.mouse_left = 1'b0;
    step();
    bus.mouse_left = 1'b1;
    repeat (2) step();
    chk("repress_armed", 32'(bus.btn_pressed), 32'd1);
    bus.mouse_left = 1'b0;
    wait_screen(2'b01, 3 * FRAME, "restart_game");

    // Asynchronous reset in the middle of a game.
    repeat (7) step();
    #2 rst = 1'b0;
    #1 chk("async_reset", 32'(dut_vec()), 32'd0);
    model_reset();
    repeat (2) step();
    rst = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        bus.mouse_x = 12'($urandom_range(380, 650));
        bus.mouse_y = 12'($urandom_range(300, 470));
      end
      if ($urandom_range(0, 11) == 0) bus.mouse_left = ~bus.mouse_left;
      bus.game_over_in = ($urandom_range(0, 299) == 0);
      bus.winner_in    = 1'($urandom_range(0, 1));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
